// File: rtl/stream_buffer_pipe.sv
// Valid/ready stream buffer with a registered head output, optional drop-on-full mode
// and a saturating drop counter.
module stream_buffer_pipe #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int DROP_MODE = 0,
    parameter int CNT_W     = 16,
    localparam int LW       = $clog2(DEPTH + 1),
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LW-1:0]     level,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [LW-1:0]     level_r, level_nxt_s;
    logic [DATA_W-1:0] out_r, out_nxt_s;
    logic [CNT_W-1:0]  drop_cnt_r, drop_cnt_nxt_s;
    logic              in_ready_r, in_ready_nxt_s, out_valid_r;
    logic              full_s, push_s, pop_s, drop_s;

    assign in_ready  = in_ready_r;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign level     = level_r;
    assign drop_cnt  = drop_cnt_r;

    // Handshake decode and next-state computation for pointers, level, head and counter.
    always_comb begin
        full_s         = (level_r == LW'(DEPTH));
        push_s         = in_valid & in_ready_r & ~full_s;
        pop_s          = out_valid_r & out_ready;
        drop_s         = (DROP_MODE != 0) & in_valid & in_ready_r & full_s;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        level_nxt_s    = level_r;
        out_nxt_s      = out_r;
        drop_cnt_nxt_s = drop_cnt_r;
        if (clear) begin
            wr_ptr_nxt_s   = PW'(0);
            rd_ptr_nxt_s   = PW'(0);
            level_nxt_s    = LW'(0);
            drop_cnt_nxt_s = CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_nxt_s = level_r + LW'(1);
                2'b01:   level_nxt_s = level_r - LW'(1);
                default: level_nxt_s = level_r;
            endcase
            if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
                drop_cnt_nxt_s = drop_cnt_r + CNT_W'(1);
            end else begin
                drop_cnt_nxt_s = drop_cnt_r;
            end
            // The new head may be the beat being written in this very cycle.
            if (level_nxt_s != LW'(0)) begin
                if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
                    out_nxt_s = in;
                end else begin
                    out_nxt_s = mem_r[rd_ptr_nxt_s];
                end
            end else begin
                out_nxt_s = out_r;
            end
        end
        if (DROP_MODE != 0) begin
            in_ready_nxt_s = 1'b1;
        end else begin
            in_ready_nxt_s = (level_nxt_s != LW'(DEPTH));
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_s && !clear) begin
            mem_r[wr_ptr_r] <= in;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r    <= PW'(0);
            rd_ptr_r    <= PW'(0);
            level_r     <= LW'(0);
            out_r       <= DATA_W'(0);
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            drop_cnt_r  <= CNT_W'(0);
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            level_r     <= level_nxt_s;
            out_r       <= out_nxt_s;
            out_valid_r <= (level_nxt_s != LW'(0));
            in_ready_r  <= in_ready_nxt_s;
            drop_cnt_r  <= drop_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_stream_buffer_pipe.sv
// Bench for stream_buffer_pipe: a backpressure instance and a drop-mode instance share
// one stimulus; a queue model is compared every cycle, plus directed literal checks.
module tb_stream_buffer_pipe;

    logic       clk = 1'b0;
    logic       reset_n, clear, in_valid, out_ready;
    logic [7:0] in_data;

    logic       rdy0, ov0, rdy1, ov1;
    logic [7:0] od0, od1;
    logic [2:0] lv0, lv1;
    logic [15:0] dc0;
    logic [1:0]  dc1;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq [2][$];
    int         mdrop [2];
    bit         mready_seen;

    always #5 clk = ~clk;

    stream_buffer_pipe #(.DATA_W(8), .DEPTH(4), .DROP_MODE(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .out(od0), .out_valid(ov0), .out_ready(out_ready),
        .level(lv0), .drop_cnt(dc0));

    stream_buffer_pipe #(.DATA_W(8), .DEPTH(4), .DROP_MODE(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .out(od1), .out_valid(ov1), .out_ready(out_ready),
        .level(lv1), .drop_cnt(dc1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO queue per instance, updated at each clock edge.
    always @(posedge clk or negedge reset_n) begin : model
        int  n;
        bit  full, rdy, push, pop, drp;
        if (!reset_n) begin
            for (int m = 0; m < 2; m++) begin
                mq[m].delete();
                mdrop[m] = 0;
            end
            mready_seen = 1'b0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (clear) begin
                    mq[m].delete();
                    mdrop[m] = 0;
                end else begin
                    n    = mq[m].size();
                    full = (n == 4);
                    rdy  = mready_seen && (m == 1 || !full);
                    push = in_valid && rdy && !full;
                    pop  = (n > 0) && out_ready;
                    drp  = (m == 1) && in_valid && full && mready_seen;
                    if (pop) void'(mq[m].pop_front());
                    if (push) mq[m].push_back(in_data);
                    if (drp && mdrop[m] < 3) mdrop[m]++;
                end
            end
            mready_seen = 1'b1;
        end
    end

    task automatic cmp_dut(input int m, input logic v, input logic [7:0] d, input logic [2:0] l,
                           input logic r, input logic [15:0] dc);
        int n;
        n = mq[m].size();
        check($sformatf("dut%0d out_valid", m), 32'(v), 32'(n > 0));
        check($sformatf("dut%0d level", m), 32'(l), 32'(n));
        check($sformatf("dut%0d in_ready", m), 32'(r), 32'(mready_seen && (m == 1 || n < 4)));
        check($sformatf("dut%0d drop_cnt", m), 32'(dc), 32'(mdrop[m]));
        if (n > 0) check($sformatf("dut%0d out", m), 32'(d), 32'(mq[m][0]));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            cmp_dut(0, ov0, od0, lv0, rdy0, dc0);
            cmp_dut(1, ov1, od1, lv1, rdy1, {14'd0, dc1});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int  idx, npop;
        bit  acc;
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;

        // Reset / idle
        #1;
        check("rst ov0", 32'(ov0), 32'd0);  check("rst ov1", 32'(ov1), 32'd0);
        check("rst lv0", 32'(lv0), 32'd0);  check("rst lv1", 32'(lv1), 32'd0);
        check("rst rdy0", 32'(rdy0), 32'd0); check("rst rdy1", 32'(rdy1), 32'd0);
        check("rst od0", 32'(od0), 32'd0);  check("rst dc1", 32'(dc1), 32'd0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        step();
        check("idle rdy0", 32'(rdy0), 32'd1); check("idle rdy1", 32'(rdy1), 32'd1);
        check("idle ov0", 32'(ov0), 32'd0);   check("idle lv0", 32'(lv0), 32'd0);

        // Pass-through
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'h11; step(); check("pt out 11", 32'(od0), 32'h11); check("pt lv a", 32'(lv0), 32'd1);
        in_data = 8'h22; step(); check("pt out 22", 32'(od0), 32'h22); check("pt lv b", 32'(lv0), 32'd1);
        in_data = 8'h33; step(); check("pt out 33", 32'(od0), 32'h33); check("pt lv c", 32'(lv0), 32'd1);
        in_valid = 1'b0; step(); check("pt empty", 32'(ov0), 32'd0);

        // Backpressure fill then drain
        out_ready = 1'b0; in_valid = 1'b1; idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_data = 8'(8'hA0 + idx); acc = rdy0; step();
            if (acc) idx++;
        end
        check("bp level", 32'(lv0), 32'd4); check("bp in_ready", 32'(rdy0), 32'd0);
        check("bp head", 32'(od0), 32'hA0); check("bp dc0", 32'(dc0), 32'd0);
        check("bp dut1 sat", 32'(dc1), 32'd3);
        out_ready = 1'b1; npop = 0;
        for (int c = 0; c < 30 && npop < 6; c++) begin
            if (idx < 6) in_data = 8'(8'hA0 + idx);
            else in_valid = 1'b0;
            acc = rdy0 && in_valid;
            if (ov0) begin
                check("bp order", 32'(od0), 32'(8'hA0 + npop));
                npop++;
            end
            step();
            if (acc) idx++;
        end
        check("bp drained", 32'(npop), 32'd6);
        in_valid = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        check("clr lv1", 32'(lv1), 32'd0); check("clr dc1", 32'(dc1), 32'd0);

        // Drop mode with 2-bit saturating counter
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'hB0 + i); step();
            check("drop rdy1", 32'(rdy1), 32'd1);
            if (i < 4) check("drop fill", 32'(lv1), 32'(i + 1));
            else check("drop cnt", 32'(dc1), 32'((i - 3) > 3 ? 3 : (i - 3)));
        end
        check("drop head1", 32'(od1), 32'hB0); check("drop lv1", 32'(lv1), 32'd4);
        check("drop head0", 32'(od0), 32'hB0); check("drop dc0", 32'(dc0), 32'd0);
        in_valid = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        check("clr2 dc1", 32'(dc1), 32'd0);

        // Full with simultaneous push/pop, pointer wrap
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hC0 + i); step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'(8'hD0 + k); step();
            if (k == 0) begin
                check("fpp lv0", 32'(lv0), 32'd3); check("fpp rdy0", 32'(rdy0), 32'd1);
                check("fpp lv1", 32'(lv1), 32'd3); check("fpp dc1", 32'(dc1), 32'd1);
            end
        end
        in_valid = 1'b0;
        repeat (6) step();
        check("fpp drain0", 32'(lv0), 32'd0); check("fpp drain1", 32'(lv1), 32'd0);

        // Clear with concurrent in_valid
        out_ready = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hE0 + i); step();
        end
        check("pre clr lv0", 32'(lv0), 32'd3);
        clear = 1'b1; in_data = 8'hEE; step();
        clear = 1'b0; in_valid = 1'b0;
        check("clr lv0", 32'(lv0), 32'd0); check("clr ov0", 32'(ov0), 32'd0);
        check("clr lv1b", 32'(lv1), 32'd0); check("clr ov1", 32'(ov1), 32'd0);
        step();
        check("clr not stored", 32'(lv0), 32'd0);

        // Asynchronous reset mid-burst
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'hF0 + i); step();
        end
        #2 reset_n = 1'b0;
        #1;
        check("arst lv0", 32'(lv0), 32'd0); check("arst ov0", 32'(ov0), 32'd0);
        check("arst rdy0", 32'(rdy0), 32'd0); check("arst od0", 32'(od0), 32'd0);
        check("arst lv1", 32'(lv1), 32'd0); check("arst dc1", 32'(dc1), 32'd0);
        in_valid = 1'b0;
        step();
        #2 reset_n = 1'b1;
        step();
        check("arst rel rdy0", 32'(rdy0), 32'd1); check("arst rel lv0", 32'(lv0), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
